inst_rom: RTL and testbench
===========================

# inst_rom

Instruction memory serving the fetch port of the `openmips` core. It answers `rom_ce_o`/`rom_addr_o` with a combinational 32-bit instruction on `rom_data_i`. It is filled at run time through a byte-wide valid/ready loader port driven by a host or bootloader. The core is held in reset while loading; during that time the block returns NOP (`0x00000000`) to any fetch.

## Interface
- `DEPTH_LOG2`, default 10: log2 of word capacity. `DEPTH = 2**DEPTH_LOG2` words.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: fetch enable, from `rom_ce_o`.
- `addr` in 32: fetch byte address, from `rom_addr_o`.
- `inst` out 32: fetched instruction, to `rom_data_i`. Combinational.
- `ld_start` in 1: one-cycle pulse that opens a load session.
- `ld_valid` in 1: loader byte valid.
- `ld_data` in 8: loader byte.
- `ld_ready` out 1: a byte is accepted when `ld_valid && ld_ready` at a rising edge.
- `ld_done` in 1: one-cycle pulse that closes the load session.
- `busy` out 1: high while in LOAD.
- `word_count` out DEPTH_LOG2+1: number of words written in the current or last session.
- `err` out 1: sticky overflow flag.

## Operation
- State machine: EMPTY, LOAD, READY.
  - `rst` forces EMPTY.
  - `ld_start` in any state goes to LOAD and clears `byte_cnt` (2b), `word_count`, the assembly register, and `err`.
  - In LOAD, `ld_done` goes to READY.
  - `ld_start` has priority over `ld_done` in the same cycle.
  - `ld_done` outside LOAD is ignored.
- Byte assembly is big-endian: byte 0 of each group goes to [31:24], byte 3 to [7:0].
  - On the 4th accepted byte, the full word is written to `mem[word_count]` at that edge and `word_count` increments. The write uses the incoming byte directly, not the registered copy.
- `ld_ready = (state==LOAD) && (word_count < DEPTH)`.
- When full (`word_count == DEPTH`), `ld_valid` high in LOAD sets `err` at the next edge. The byte is dropped and `err` stays set until the next `ld_start` or `rst`.
- `ld_done` with `byte_cnt != 0`: the partial word is written zero-padded in its low bytes and `word_count` increments.
  - If a byte is accepted in the same cycle, it is included first.
  - If that byte completes a word, only that word is written and no padded word follows.
- Fetch: `idx = addr[DEPTH_LOG2+1:2]`. `addr[1:0]` is ignored.
  - `inst = mem[idx]` only when `ce==1`, state is READY, `addr[31:DEPTH_LOG2+2]==0`, and `idx < word_count`.
  - Otherwise `inst = 32'h0`.
- Memory array contents are not reset. Unwritten locations are unreachable because of the `word_count` gating.

## Timing
- Reset values: state EMPTY, `inst` 0, `ld_ready` 0, `busy` 0, `word_count` 0, `err` 0.
- `inst` has zero-cycle latency from `ce`/`addr`. This is required because the core's IF/ID register samples `pc` and `rom_data_i` on the same edge.
- `ld_ready` and `busy` are decoded from registered state.
  - `ld_ready` rises the cycle after the `ld_start` edge.
  - `ld_ready` falls the cycle after the edge that fills the last word.
- `word_count` and `err` update at the accepting edge and are visible from the next cycle.
- READY is entered at the `ld_done` edge. A fetch of the last word is valid from the following cycle.
- There is no write/read overlap: reads return 0 whenever state is not READY.
- `rst` asserted mid-session: immediate return to EMPTY. Any partial word is discarded and `inst` is 0 at once, without waiting for a clock.
- The loader may hold `ld_valid` high continuously, for a throughput of one byte per cycle.

## Test plan
1. **Reset:** assert `rst` asynchronously between edges.
   - Required: `inst`=0, `ld_ready`=0, `busy`=0, `word_count`=0, `err`=0 immediately.
   - After release, `ce`=1, `addr`=0: `inst`=0.
2. **Basic load:**
   - Stimulus: `ld_start`, then bytes 34 01 11 00 34 02 00 20 back-to-back, then `ld_done`.
   - Required: `word_count`=2.
   - `addr` 0x0 → `0x34011100`, 0x4 → `0x34020020`, 0x8 → 0, 0x6 → `0x34020020`.
   - `ce`=0 → 0.
3. **Partial word:**
   - Stimulus: `ld_start`, bytes 11 22 33 44 AB, with `ld_done` in the same cycle as byte AB.
   - Required: `word_count`=2, `addr` 0x4 → `0xAB000000`.
   - Repeat with 11 22 33 44 and `ld_done` on byte 44 → `word_count`=1.
4. **Overflow**, with `DEPTH_LOG2`=2:
   - Stimulus: 17 bytes with `ld_valid` held high.
   - Required: 16 bytes accepted, `ld_ready` low after the 16th, `err`=1 after the 17th, `word_count`=4.
   - After `ld_done`, `addr` 0x10 (out of range) → 0.
5. **Reload and reset mid-session:**
   - In READY, pulse `ld_start`. Required: `inst`=0 and `busy`=1 next cycle, `word_count`=0, `err` cleared.
   - After 2 bytes, assert `rst`. Required: EMPTY, then a fresh 4-byte load reads back correctly.
6. **Priority:**
   - `ld_start` and `ld_done` in the same cycle in LOAD. Required: stays in LOAD, `word_count`=0.
   - `ld_done` while in EMPTY: ignored, state stays EMPTY.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction memory for the openmips fetch port. It is loaded at run time
// through a byte-wide valid/ready port and answers fetches combinationally.
module inst_rom #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  input  logic                  ld_done,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [1:0]              byte_cnt;
  logic [23:0]             asm_word;
  logic [31:0]             mem [DEPTH];
  logic                    accept;
  logic                    wr_en;
  logic [31:0]             wr_word;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_addr_lsb;

  assign ld_ready = (state == LOAD) && (word_count < CW'(DEPTH));
  assign busy     = (state == LOAD);
  assign accept   = ld_valid && ld_ready;

  // Next-state logic; a load start always wins over a load done.
  always_comb begin
    state_nx = state;
    if (ld_start) begin
      state_nx = LOAD;
    end else if ((state == LOAD) && ld_done) begin
      state_nx = READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Word being written: registered bytes plus the incoming byte, zero-padded below.
  always_comb begin
    wr_word = {asm_word, 8'h00};
    if (accept) begin
      case (byte_cnt)
        2'd0:    wr_word[31:24] = ld_data;
        2'd1:    wr_word[23:16] = ld_data;
        2'd2:    wr_word[15:8]  = ld_data;
        default: wr_word[7:0]   = ld_data;
      endcase
    end
    wr_en = (state == LOAD) && !ld_start &&
            ((accept && (byte_cnt == 2'd3)) ||
             (ld_done && (accept || (byte_cnt != 2'd0))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      asm_word   <= 24'h0;
      word_count <= '0;
      err        <= 1'b0;
    end else if (ld_start) begin
      byte_cnt   <= 2'd0;
      asm_word   <= 24'h0;
      word_count <= '0;
      err        <= 1'b0;
    end else if (state == LOAD) begin
      if (wr_en) begin
        word_count <= word_count + CW'(1);
      end
      if (wr_en || ld_done) begin
        byte_cnt <= 2'd0;
        asm_word <= 24'h0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_word <= wr_word[31:8];
      end
      // In LOAD, ready is low only when the memory is full.
      if (ld_valid && !ld_ready) begin
        err <= 1'b1;
      end
    end
  end

  // Storage is not reset; word_count gating hides unwritten locations.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count[DEPTH_LOG2-1:0]] <= wr_word;
    end
  end

  assign idx             = addr[DEPTH_LOG2+1:2];
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    inst = 32'h0;
    if (ce && (state == READY) && (addr[31:DEPTH_LOG2+2] == '0) &&
        (CW'(idx) < word_count)) begin
      inst = mem[idx];
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// Directed self-checking bench for inst_rom: a default-depth instance and a
// 4-word instance used for the overflow and reload scenarios.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] inst;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h0;
  logic        ld_ready;
  logic        ld_done = 1'b0;
  logic        busy;
  logic [10:0] word_count;
  logic        err;

  logic        s_ce = 1'b0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_inst;
  logic        s_ld_start = 1'b0;
  logic        s_ld_valid = 1'b0;
  logic [7:0]  s_ld_data = 8'h0;
  logic        s_ld_ready;
  logic        s_ld_done = 1'b0;
  logic        s_busy;
  logic [2:0]  s_word_count;
  logic        s_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_rom dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy),
    .word_count(word_count), .err(err)
  );

  inst_rom #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rst(rst), .ce(s_ce), .addr(s_addr), .inst(s_inst),
    .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_data(s_ld_data),
    .ld_ready(s_ld_ready), .ld_done(s_ld_done), .busy(s_busy),
    .word_count(s_word_count), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_pulse();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic done_pulse();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, inst, exp);
  endtask

  task automatic s_send(input logic [7:0] b);
    s_ld_valid = 1'b1;
    s_ld_data  = b;
    tick();
    s_ld_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};

    // Reset applied between edges takes effect without a clock
    #2 rst = 1'b1;
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wc", 32'(word_count), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    ce = 1'b1;
    fetch("empty_fetch", 32'h0, 32'h0);

    // Basic two-word load
    start_pulse();
    chk("ld_busy", 32'(busy), 32'h1);
    chk("ld_ready_up", 32'(ld_ready), 32'h1);
    for (int i = 0; i < 8; i++) send(prog[i]);
    done_pulse();
    chk("basic_wc", 32'(word_count), 32'd2);
    chk("basic_busy", 32'(busy), 32'h0);
    fetch("basic_a0", 32'h0, 32'h34011100);
    fetch("basic_a4", 32'h4, 32'h34020020);
    fetch("basic_a8", 32'h8, 32'h0);
    fetch("basic_a6", 32'h6, 32'h34020020);
    ce = 1'b0;
    fetch("basic_ce0", 32'h0, 32'h0);
    ce = 1'b1;

    // Partial word closed together with its first byte
    start_pulse();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    ld_done = 1'b1;
    send(8'hAB);
    ld_done = 1'b0;
    chk("part_wc", 32'(word_count), 32'd2);
    fetch("part_a4", 32'h4, 32'hAB000000);
    fetch("part_a0", 32'h0, 32'h11223344);

    // Done on the byte completing a word: no extra padded word
    start_pulse();
    send(8'h11); send(8'h22); send(8'h33);
    ld_done = 1'b1;
    send(8'h44);
    ld_done = 1'b0;
    chk("full_wc", 32'(word_count), 32'd1);
    fetch("full_a0", 32'h0, 32'h11223344);
    fetch("full_a4", 32'h4, 32'h0);

    // Start and done together in LOAD: start wins
    start_pulse();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("prio_wc_pre", 32'(word_count), 32'd1);
    ld_start = 1'b1;
    ld_done  = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_done  = 1'b0;
    chk("prio_busy", 32'(busy), 32'h1);
    chk("prio_wc", 32'(word_count), 32'd0);
    fetch("prio_inst", 32'h0, 32'h0);

    // Done while EMPTY is ignored
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_pulse();
    chk("empty_done_busy", 32'(busy), 32'h0);
    chk("empty_done_ready", 32'(ld_ready), 32'h0);
    fetch("empty_done_inst", 32'h0, 32'h0);

    // Overflow on the 4-word instance with valid held high
    s_ce = 1'b1;
    s_ld_start = 1'b1;
    tick();
    s_ld_start = 1'b0;
    s_ld_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_ld_data = 8'(i);
      tick();
    end
    chk("ovf_ready_low", 32'(s_ld_ready), 32'h0);
    chk("ovf_wc", 32'(s_word_count), 32'd4);
    chk("ovf_err_pre", 32'(s_err), 32'h0);
    s_ld_data = 8'hFF;
    tick();
    s_ld_valid = 1'b0;
    chk("ovf_err", 32'(s_err), 32'h1);
    chk("ovf_wc_hold", 32'(s_word_count), 32'd4);
    s_ld_done = 1'b1;
    tick();
    s_ld_done = 1'b0;
    s_addr = 32'hC;  #1; chk("ovf_a12", s_inst, 32'h0C0D0E0F);
    s_addr = 32'h0;  #1; chk("ovf_a0", s_inst, 32'h00010203);
    s_addr = 32'h10; #1; chk("ovf_a16", s_inst, 32'h0);
    chk("ovf_err_sticky", 32'(s_err), 32'h1);

    // Reload from READY, then reset mid-session
    s_addr = 32'h0;
    s_ld_start = 1'b1;
    tick();
    s_ld_start = 1'b0;
    chk("rl_inst", s_inst, 32'h0);
    chk("rl_busy", 32'(s_busy), 32'h1);
    chk("rl_wc", 32'(s_word_count), 32'd0);
    chk("rl_err", 32'(s_err), 32'h0);
    s_send(8'hAA); s_send(8'hBB);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(s_busy), 32'h0);
    chk("mid_rst_ready", 32'(s_ld_ready), 32'h0);
    chk("mid_rst_inst", s_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    s_ld_start = 1'b1;
    tick();
    s_ld_start = 1'b0;
    s_send(8'hDE); s_send(8'hAD); s_send(8'hBE); s_send(8'hEF);
    s_ld_done = 1'b1;
    tick();
    s_ld_done = 1'b0;
    chk("fresh_wc", 32'(s_word_count), 32'd1);
    s_addr = 32'h0; #1; chk("fresh_a0", s_inst, 32'hDEADBEEF);
    s_addr = 32'h4; #1; chk("fresh_a4", s_inst, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
